// File: rtl/counter_bank.sv
// Bank of CHANNELS wide event counters with per-channel inhibit, sticky overflow
// status and a registered overflow interrupt, all behind a small register map.
module counter_bank #(
  parameter int XLEN     = 32,
  parameter int WIDTH    = 64,
  parameter int CHANNELS = 4,
  localparam int AW      = $clog2(2*CHANNELS+3)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [CHANNELS-1:0] events,
  input  logic [AW-1:0]       addr,
  input  logic                we,
  input  logic [XLEN-1:0]     wd,
  output logic [XLEN-1:0]     rd,
  output logic                irq
);

  localparam int HW = WIDTH - XLEN;
  localparam logic [AW-1:0] A_INH = AW'(2*CHANNELS);
  localparam logic [AW-1:0] A_OVF = AW'(2*CHANNELS+1);
  localparam logic [AW-1:0] A_IEN = AW'(2*CHANNELS+2);
  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0]    cnt_q [CHANNELS];
  logic [WIDTH-1:0]    cnt_d [CHANNELS];
  logic [CHANNELS-1:0] inhibit_q, inhibit_d;
  logic [CHANNELS-1:0] ovf_q, ovf_d;
  logic [CHANNELS-1:0] irq_en_q, irq_en_d;
  logic                irq_q, irq_d;
  logic [CHANNELS-1:0] ovf_set_s;
  logic [XLEN-1:0]     chan_rd_s;
  logic [XLEN-1:0]     rd_s;

  // Next-state: a write to either counter half wins over that channel's increment.
  always_comb begin
    ovf_set_s = {CHANNELS{1'b0}};
    for (int i = 0; i < CHANNELS; i++) begin
      cnt_d[i] = cnt_q[i];
      if (we && (addr == AW'(2*i))) begin
        cnt_d[i][XLEN-1:0] = wd;
      end else if (we && (addr == AW'(2*i+1))) begin
        cnt_d[i][WIDTH-1:XLEN] = wd[HW-1:0];
      end else if (events[i] && !inhibit_q[i]) begin
        cnt_d[i]     = cnt_q[i] + ONE;
        ovf_set_s[i] = &cnt_q[i];
      end else begin
        cnt_d[i] = cnt_q[i];
      end
    end

    if (we && (addr == A_INH)) begin
      inhibit_d = wd[CHANNELS-1:0];
    end else begin
      inhibit_d = inhibit_q;
    end

    if (we && (addr == A_IEN)) begin
      irq_en_d = wd[CHANNELS-1:0];
    end else begin
      irq_en_d = irq_en_q;
    end

    // Fresh overflows are ORed in after the clear so a same-cycle set survives.
    if (we && (addr == A_OVF)) begin
      ovf_d = (ovf_q & ~wd[CHANNELS-1:0]) | ovf_set_s;
    end else begin
      ovf_d = ovf_q | ovf_set_s;
    end

    irq_d = |(ovf_d & irq_en_d);
  end

  // Read mux over pre-edge state; unmapped addresses fall through to zero.
  always_comb begin
    chan_rd_s = {XLEN{1'b0}};
    for (int i = 0; i < CHANNELS; i++) begin
      chan_rd_s = chan_rd_s
                | ({XLEN{addr == AW'(2*i)}}   & cnt_q[i][XLEN-1:0])
                | ({XLEN{addr == AW'(2*i+1)}} & XLEN'(cnt_q[i][WIDTH-1:XLEN]));
    end
    case (addr)
      A_INH:   rd_s = XLEN'(inhibit_q);
      A_OVF:   rd_s = XLEN'(ovf_q);
      A_IEN:   rd_s = XLEN'(irq_en_q);
      default: rd_s = chan_rd_s;
    endcase
  end

  // State registers with asynchronous active-low clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < CHANNELS; i++) begin
        cnt_q[i] <= {WIDTH{1'b0}};
      end
      inhibit_q <= {CHANNELS{1'b0}};
      ovf_q     <= {CHANNELS{1'b0}};
      irq_en_q  <= {CHANNELS{1'b0}};
      irq_q     <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      inhibit_q <= inhibit_d;
      ovf_q     <= ovf_d;
      irq_en_q  <= irq_en_d;
      irq_q     <= irq_d;
    end
  end

  assign rd  = rd_s;
  assign irq = irq_q;

endmodule

// File: tb/tb_counter_bank.sv
// Scoreboard bench for counter_bank: directed scenarios plus random traffic,
// each cycle's expected read/irq queued by a behavioural model and popped by a monitor.
module tb_counter_bank;
  localparam int XLEN = 32;
  localparam int WIDTH = 64;
  localparam int CH = 4;
  localparam int AW = $clog2(2*CH+3);

  logic            clk;
  logic            reset;
  logic [CH-1:0]   events;
  logic [AW-1:0]   addr;
  logic            we;
  logic [XLEN-1:0] wd;
  logic [XLEN-1:0] rd;
  logic            irq;

  counter_bank #(.XLEN(XLEN), .WIDTH(WIDTH), .CHANNELS(CH)) dut (
    .clk(clk), .reset(reset), .events(events), .addr(addr),
    .we(we), .wd(wd), .rd(rd), .irq(irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [XLEN-1:0] rd;
    logic            irq;
    string           name;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0;
  int failures = 0;

  logic [WIDTH-1:0] m_cnt [CH];
  logic [CH-1:0]    m_inh, m_ovf, m_ien;
  logic             m_irq;

  task automatic model_reset();
    for (int c = 0; c < CH; c++) m_cnt[c] = 64'd0;
    m_inh = 4'd0; m_ovf = 4'd0; m_ien = 4'd0; m_irq = 1'b0;
  endtask

  function automatic logic [XLEN-1:0] model_read(int a);
    if (a < 2*CH) begin
      if (a % 2 == 0) return m_cnt[a/2][31:0];
      else return m_cnt[a/2][63:32];
    end
    if (a == 2*CH) return {28'd0, m_inh};
    if (a == 2*CH+1) return {28'd0, m_ovf};
    if (a == 2*CH+2) return {28'd0, m_ien};
    return 32'd0;
  endfunction

  // One clock edge worth of register-map rules applied to the model.
  task automatic model_step(logic [CH-1:0] ev, int a, logic w, logic [XLEN-1:0] d);
    logic [CH-1:0] set;
    set = 4'd0;
    for (int c = 0; c < CH; c++) begin
      if (w && a == 2*c) m_cnt[c] = {m_cnt[c][63:32], d};
      else if (w && a == 2*c+1) m_cnt[c] = {d, m_cnt[c][31:0]};
      else if (ev[c] && !m_inh[c]) begin
        if (m_cnt[c] == 64'hFFFF_FFFF_FFFF_FFFF) begin
          m_cnt[c] = 64'd0;
          set[c] = 1'b1;
        end else begin
          m_cnt[c] = m_cnt[c] + 64'd1;
        end
      end
    end
    if (w && a == 2*CH+1) m_ovf = m_ovf & ~d[CH-1:0];
    m_ovf = m_ovf | set;
    if (w && a == 2*CH) m_inh = d[CH-1:0];
    if (w && a == 2*CH+2) m_ien = d[CH-1:0];
    m_irq = |(m_ovf & m_ien);
  endtask

  // Called just after a rising edge: drive, queue expectation, advance to next edge.
  task automatic cycle(logic [CH-1:0] ev, int a, logic w, logic [XLEN-1:0] d, string name);
    exp_t e;
    events = ev; addr = AW'(a); we = w; wd = d;
    e.rd = model_read(a); e.irq = m_irq; e.name = name;
    exp_q.push_back(e);
    @(posedge clk);
    model_step(ev, a, w, d);
    #1;
  endtask

  task automatic rd_at(int a, string name);
    cycle(4'd0, a, 1'b0, 32'd0, name);
  endtask

  task automatic direct_check(logic [XLEN-1:0] got_rd, logic got_irq,
                              logic [XLEN-1:0] want_rd, logic want_irq, string name);
    checks++;
    if (got_rd !== want_rd || got_irq !== want_irq) begin
      failures++;
      $display("FAIL %s rd=%h irq=%b expected rd=%h irq=%b", name, got_rd, got_irq, want_rd, want_irq);
    end
  endtask

  // Monitor: rd/irq are presented every cycle; compare against the queued expectation.
  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      exp_t e;
      e = exp_q.pop_front();
      checks++;
      if (rd !== e.rd || irq !== e.irq) begin
        failures++;
        $display("FAIL %s rd=%h irq=%b expected rd=%h irq=%b", e.name, rd, irq, e.rd, e.irq);
      end
    end
  end

  initial begin
    reset = 1'b0; events = 4'd0; addr = 4'd0; we = 1'b0; wd = 32'd0;
    model_reset();
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;

    for (int a = 0; a <= 2*CH+2; a++) rd_at(a, "reset_state");

    for (int k = 0; k < 10; k++) cycle(4'h1, 0, 1'b0, 32'd0, "count10");
    rd_at(0, "count10_a0");
    rd_at(2, "count10_a2");

    cycle(4'h0, 0, 1'b1, 32'hFFFF_FFFF, "carry_wr");
    cycle(4'h1, 0, 1'b0, 32'd0, "carry_inc");
    rd_at(0, "carry_lo");
    rd_at(1, "carry_hi");
    rd_at(2*CH+1, "carry_ovf");

    cycle(4'h0, 2, 1'b1, 32'hFFFF_FFFF, "ovf_ld_lo");
    cycle(4'h0, 3, 1'b1, 32'hFFFF_FFFF, "ovf_ld_hi");
    cycle(4'h0, 2*CH+2, 1'b1, 32'h2, "ovf_ien");
    cycle(4'h2, 2*CH+1, 1'b0, 32'd0, "ovf_wrap");
    rd_at(2*CH+1, "ovf_status_irq");
    rd_at(2, "ovf_cnt_lo");
    rd_at(3, "ovf_cnt_hi");
    cycle(4'h0, 2*CH+1, 1'b1, 32'h2, "ovf_w1c");
    rd_at(2*CH+1, "ovf_cleared");

    cycle(4'h0, 2*CH, 1'b1, 32'h1, "inh_set");
    for (int k = 0; k < 5; k++) cycle(4'hF, 2*CH, 1'b0, 32'd0, "inh_count");
    for (int a = 0; a < 2*CH; a += 2) rd_at(a, "inh_read");
    cycle(4'h0, 2*CH, 1'b1, 32'h0, "inh_clr");
    cycle(4'h1, 0, 1'b1, 32'h1234_5678, "write_wins");
    rd_at(0, "write_wins_rd");

    cycle(4'h0, 4, 1'b1, 32'hFFFF_FFFF, "race_lo");
    cycle(4'h0, 5, 1'b1, 32'hFFFF_FFFF, "race_hi");
    cycle(4'h4, 2*CH+1, 1'b1, 32'h4, "race_w1c");
    rd_at(2*CH+1, "race_ovf");
    cycle(4'h0, 2*CH+2, 1'b1, 32'h4, "race_ien");
    rd_at(4, "race_irq");

    cycle(4'h0, 0, 1'b1, 32'd0, "rst_clr0");
    for (int k = 0; k < 7; k++) cycle(4'h1, 0, 1'b0, 32'd0, "pre_rst");
    rd_at(0, "pre_rst_rd");
    events = 4'h1; addr = 4'd0; we = 1'b0;
    #2 reset = 1'b0;
    #1 direct_check(rd, irq, 32'd0, 1'b0, "async_rst");
    addr = AW'(2*CH+1);
    #0.5 direct_check(rd, irq, 32'd0, 1'b0, "async_rst_ovf");
    model_reset();
    #0.5 reset = 1'b1;
    @(posedge clk); #1;
    model_step(4'h1, 2*CH+1, 1'b0, 32'd0);
    rd_at(0, "resume");

    for (int k = 0; k < 400; k++) begin
      logic [CH-1:0] ev;
      int a;
      logic w;
      logic [XLEN-1:0] d;
      ev = 4'($urandom);
      a = $urandom_range(0, 15);
      w = ($urandom_range(0, 9) < 3);
      d = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : 32'($urandom);
      if (a == 2*CH && w) d = 32'($urandom_range(0, 3));
      cycle(ev, a, w, d, "random");
    end

    @(negedge clk); #1;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain pending=%0d expected 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout reached expected finish");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/counter_bank.md
COUNTER_BANK -- requirements
Module: counter_bank

Interface
REQ-001 Parameter XLEN, default 32: width of the register read/write data bus.
REQ-002 Parameter WIDTH, default 64: counter width; legal range XLEN+1 .. 2*XLEN.
REQ-003 Parameter CHANNELS, default 4: number of independent counters; legal range 1 .. XLEN.
REQ-004 Derived AW = $clog2(2*CHANNELS+3): register address width.
REQ-005 clk  input  1  sole clock; all state updates on rising edge.
REQ-006 reset  input  1  asynchronous, active-low reset.
REQ-007 event  input  CHANNELS  per-channel increment request, sampled each cycle.
REQ-008 addr  input  AW  register select.
REQ-009 we  input  1  write strobe for the register selected by addr.
REQ-010 wd  input  XLEN  write data.
REQ-011 rd  output  XLEN  combinational read data for the register selected by addr.
REQ-012 irq  output  1  registered overflow interrupt.

Function
REQ-013 Address map: 2*i = counter i bits [XLEN-1:0]; 2*i+1 = counter i bits [WIDTH-1:XLEN], zero-extended on read; 2*CHANNELS = INHIBIT mask; 2*CHANNELS+1 = OVF status; 2*CHANNELS+2 = IRQ_EN mask.
REQ-014 INHIBIT, OVF, IRQ_EN occupy bits [CHANNELS-1:0]; upper bits read 0, ignore writes.
REQ-015 Unmapped addresses read 0; writes to them have no effect.
REQ-016 Channel i increments by exactly 1 in a cycle when event[i]=1, INHIBIT[i]=0, and no write targets either half of counter i.
REQ-017 A write to a counter half replaces that half with wd (hi half: low WIDTH-XLEN bits of wd); the other half holds; no increment that cycle (write wins).
REQ-018 Counter at all-ones that increments wraps to 0 and sets OVF[i] in the same edge.
REQ-019 OVF is sticky; a write to OVF clears each bit where wd[i]=1 (write-1-to-clear).
REQ-020 New overflow of channel i in the same cycle as a W1C of OVF[i]: set wins, OVF[i]=1.
REQ-021 Carry from low half to high half is internal; increment is full-WIDTH, single cycle, no split latency.
REQ-022 INHIBIT and IRQ_EN are plain read/write; new values take effect from the next cycle.
REQ-023 irq registered: next irq = |(OVF_next & IRQ_EN_next); irq rises the cycle after the overflowing edge.
REQ-024 rd reflects state current in the cycle (pre-edge); a read and write to same address in one cycle returns old value.
REQ-025 Channels fully independent; simultaneous events on all channels all counted.

Reset
REQ-026 reset=0 asynchronously forces all counters 0, INHIBIT 0, OVF 0, IRQ_EN 0, irq 0, regardless of clk.
REQ-027 Reset asserted mid-count discards pending increments/writes; first count after release occurs on the first rising edge with reset=1.
REQ-028 rd is combinational from reset state during reset (counter reads return 0).

Verification
REQ-029 Reset, event[0]=1 for 10 cycles, others 0 -> addr 0 reads 10, addr 2 reads 0, irq 0.
REQ-030 Write 0xFFFFFFFF to addr 0, event[0]=1 one cycle -> addr 0 reads 0, addr 1 reads 1, OVF 0.
REQ-031 Load counter 1 to all-ones (addr 2, 3 = 0xFFFFFFFF), IRQ_EN=0x2, event[1]=1 one cycle -> counter 1 = 0, OVF=0x2, irq=1 next cycle; write OVF=0x2 -> OVF 0, irq 0 next cycle.
REQ-032 INHIBIT=0x1, event=0xF for 5 cycles -> channel 0 unchanged, channels 1..3 read 5; write to addr 0 with event[0]=1 and INHIBIT=0 -> counter = wd, no +1.
REQ-033 Counter 2 at all-ones, event[2]=1 concurrent with OVF W1C of bit 2 -> OVF[2]=1 after edge.
REQ-034 reset pulsed low between clock edges after 7 counts -> counters 0 immediately, irq 0, counting resumes first edge after release.
